seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed 7-segment scanner for the counter display. Consumes the synchronized reset
//  from the reset synchronizer and a packed hex value from the counter. Drives one digit at a
//  time: active-low anodes, active-low segments, decimal point. Display data is snapshotted at
//  frame boundaries so digits never tear.
// PARAMETERS
//  NUM_DIGITS  8        digits scanned; legal range 2..8
//  DIV_COUNT   100000   clk cycles per digit slot; 1 ms at 100 MHz; must be >= 2
//  GUARD       16       cycles at the start of each slot with all anodes off (anti-ghost); < DIV_COUNT
// PORTS
//  clk        in   1             system clock
//  rst        in   1             synchronous, active-high reset; driven by the reset synchronizer output
//  value      in   4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]
//  blank      in   NUM_DIGITS    1 = digit k held dark
//  dp         in   NUM_DIGITS    1 = decimal point lit on digit k
//  enable     in   1             0 = whole display dark; scanning continues
//  an         out  NUM_DIGITS    anodes, active-low, one-hot-low when lit
//  seg        out  7             {g,f,e,d,c,b,a}, active-low
//  dp_n       out  1             decimal point, active-low
//  frame_tick out  1             1-cycle pulse at each frame boundary
// BEHAVIOUR
//  - One clock, clk. rst is synchronous and active-high. All outputs are registered.
//  - Reset values: an = all 1s, seg = 7'h7F, dp_n = 1, frame_tick = 0. Divider, idx and GUARD
//    count = 0. Shadow value/blank/dp = 0.
//  - rst asserted mid-operation: reset values appear at the next clk edge. Scanning restarts at digit 0.
//  - Divider cnt counts 0..DIV_COUNT-1 and wraps to 0. slot_tick = (cnt == DIV_COUNT-1).
//  - On slot_tick, idx advances modulo NUM_DIGITS.
//  - On slot_tick with idx == NUM_DIGITS-1, in the same edge:
//    - idx wraps to 0;
//    - shadow regs capture value/blank/dp;
//    - frame_tick = 1 for exactly that one cycle.
//  - Frame period = NUM_DIGITS*DIV_COUNT cycles. Input changes mid-frame are invisible until the next capture.
//  - Until the first capture after reset, shadow = 0, so digits would show "0".
//  - Output stage, 1-cycle latency from idx/cnt/shadow:
//    - lit = enable & ~shadow_blank[idx] & (cnt >= GUARD).
//    - an[idx] = ~lit. All other an bits = 1.
//    - seg = lit ? hex2seg(shadow_value[idx]) : 7'h7F.
//    - dp_n = ~(lit & shadow_dp[idx]).
//  - hex2seg (active-low {g..a}):
//    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//  - Widths:
//    - idx = $clog2(NUM_DIGITS) bits. idx wraps explicitly at NUM_DIGITS-1; it does not rely on
//      power-of-2 overflow.
//    - cnt = $clog2(DIV_COUNT) bits.
//  - enable = 0: divider, idx, capture and frame_tick run normally; only the outputs are dark.
//  - GUARD = 0: no dark interval.
// STRUCTURE
//  - Shared include seg7_defs.vh: SEG_OFF = 7'h7F, AN_OFF pattern, the hex2seg table above as a function.
//  - One sub-module hex_to_seg7 (4-bit in, 7-bit active-low out, combinational), instantiated once on
//    the selected shadow nibble.
//  - Top holds the divider, idx, shadow regs and output regs.
// TESTING  (NUM_DIGITS=4, DIV_COUNT=4, GUARD=1; frame = 16 cycles)
//  1. Hold rst 5 cycles with value=16'hFFFF, enable=1.
//     -> an=4'hF, seg=7'h7F, dp_n=1, frame_tick=0 every cycle.
//  2. value=16'h1234, release rst.
//     -> after the first frame_tick, digit 0 slot: an=4'b1110, seg=7'h19 ("4") on cycles 2..4 of the slot.
//     -> slot cycle 1 (guard): an=4'hF.
//     -> next slots show 3,2,1 on an[1..3].
//  3. Change value to 16'h0000 mid-frame.
//     -> remaining digits of that frame still show 1234.
//     -> zeros (seg=7'h40) appear only after the next frame_tick.
//  4. blank=4'b0100 -> an[2] never 0.
//     enable=0 -> an=4'hF constantly, while frame_tick still pulses every 16 cycles.
//  5. value=16'hF018, dp=4'b0001.
//     -> digit 0: seg=7'h00 with dp_n=0, only while an[0]=0.
//     -> digit 3: seg=7'h0E.
//  6. Assert rst during the digit-2 slot.
//     -> next edge gives reset values.
//     -> after release, scanning restarts at digit 0 with shadow=0.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scanner: dark-segment pattern and the
// active-low hex glyph table ({g,f,e,d,c,b,a}).
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] glyph;
    case (hex)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner. Display data is snapshotted once per frame
// so a digit never shows a mix of old and new values; all outputs are registered.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_COUNT  = 100000,
  parameter int GUARD      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      enable,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic                      frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(DIV_COUNT);

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0]      GUARD_C  = CNT_W'(GUARD);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    slot_tick;
  logic                    frame_end;
  logic                    guard_ok;
  logic                    lit;
  logic [3:0]              sel_nib;
  logic                    sel_blank;
  logic                    sel_dp;
  logic [6:0]              sel_seg;
  logic [NUM_DIGITS-1:0]   an_next;

  assign slot_tick = (cnt == CNT_LAST);
  assign frame_end = slot_tick && (idx == IDX_LAST);

  // A zero-length guard would make the comparison constant, so it is elided.
  if (GUARD == 0) begin : g_no_guard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (cnt >= GUARD_C);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_nib   = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_nib   = shadow_value[4*k +: 4];
        sel_blank = shadow_blank[k];
        sel_dp    = shadow_dp[k];
      end
    end
    lit = enable && !sel_blank && guard_ok;
    an_next = AN_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) an_next[k] = ~lit;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (sel_nib),
    .seg_n  (sel_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      // NOTE: the shadow registers are reset deliberately; the first frame must show zeros, not X.
      shadow_value <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      frame_tick   <= 1'b0;
      an           <= AN_OFF;
      seg          <= SEG_OFF;
      dp_n         <= 1'b1;
    end else begin
      cnt <= slot_tick ? '0 : cnt + 1'b1;
      if (slot_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        shadow_value <= value;
        shadow_blank <= blank;
        shadow_dp    <= dp;
      end
      frame_tick <= frame_end;
      an         <= an_next;
      seg        <= lit ? sel_seg : SEG_OFF;
      dp_n       <= ~(lit && sel_dp);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-cycle slots and a 1-cycle guard.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  int compared;
  int mismatched;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIV_COUNT  (4),
    .GUARD      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .blank      (blank),
    .dp         (dp),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered glyph table.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected {an, seg, dp_n, frame_tick} on sample j (1..16) after a frame boundary,
  // for the shadow contents v/b/d captured at that boundary.
  function automatic logic [12:0] frame_exp(input int j, input logic [15:0] v,
                                            input logic [3:0] b, input logic [3:0] d,
                                            input logic en);
    int         s;
    int         c;
    logic       l;
    logic [3:0] a;
    logic [3:0] nib;
    logic [6:0] sg;
    s   = (j - 1) / 4;
    c   = (j - 1) % 4;
    l   = en && !b[s] && (c >= 1);
    a   = 4'hF;
    nib = v[4*s +: 4];
    if (l) a[s] = 1'b0;
    sg  = l ? glyph(nib) : 7'h7F;
    return {a, sg, ~(l & d[s]), (j == 16)};
  endfunction

  localparam logic [12:0] RESET_EXP = {4'hF, 7'h7F, 1'b1, 1'b0};

  task automatic test_reset();
    rst    = 1'b1;
    value  = 16'hFFFF;
    blank  = 4'h0;
    dp     = 4'h0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== RESET_EXP) begin
        mismatched++;
        $display("FAIL reset cycle %0d: got an=%h seg=%h dp_n=%b ft=%b, want %h", i,
                 an, seg, dp_n, frame_tick, RESET_EXP);
      end
    end
  endtask

  task automatic test_scan();
    logic [12:0] e;
    value = 16'h1234;
    rst   = 1'b0;
    // Before the first capture the shadow is zero.
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL scan_first_frame j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h1234, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL scan_1234 j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_frame_snapshot();
    logic [12:0] e;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h1234, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL snapshot_hold j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
      if (j == 6) value = 16'h0000;
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL snapshot_zero j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_blank_enable();
    logic [12:0] e;
    blank = 4'b0100;
    // Blank is snapshotted too: this frame is still unblanked.
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL blank_pending j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'b0100, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL blank_digit2 j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    enable = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'b0100, 4'h0, 1'b0);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL disabled j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_dp_hex();
    logic [12:0] e;
    enable = 1'b1;
    blank  = 4'h0;
    value  = 16'hF018;
    dp     = 4'b0001;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'b0100, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL dp_pending j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'hF018, 4'h0, 4'b0001, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL dp_f018 j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] e;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'hF018, 4'h0, 4'b0001, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL pre_reset j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    // Now in the digit-2 slot.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== RESET_EXP) begin
        mismatched++;
        $display("FAIL mid_reset cycle %0d: got an=%h seg=%h dp_n=%b ft=%b, want %h", i,
                 an, seg, dp_n, frame_tick, RESET_EXP);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'h0000, 4'h0, 4'h0, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL restart_zero j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = frame_exp(j, 16'hF018, 4'h0, 4'b0001, 1'b1);
      compared++;
      if ({an, seg, dp_n, frame_tick} !== e) begin
        mismatched++;
        $display("FAIL restart_f018 j=%0d: got an=%h seg=%h dp_n=%b ft=%b, want an=%h seg=%h dp_n=%b ft=%b",
                 j, an, seg, dp_n, frame_tick, e[12:9], e[8:2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_scan();
    test_frame_snapshot();
    test_blank_enable();
    test_dp_hex();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
